// File: rtl/bounce_gen.sv
// Mechanical switch emulator: each clean_in change is replayed on noisy_out as an
// LFSR-timed burst of bounce edges followed by a settle hold. Define
// BOUNCE_GEN_EDGE_COUNT_EN to add an 8-bit running count of noisy_out toggles.
module bounce_gen #(
  parameter int unsigned MAX_BOUNCES   = 7,
  parameter int unsigned DWELL_BITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clean_in,
  output logic       noisy_out,
  output logic       busy,
  output logic       done
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
  ,
  output logic [7:0] edge_count
`endif
);

  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam int unsigned TOG_MAX  = 2 * MAX_BOUNCES + 1;
  localparam int unsigned TOG_W    = $clog2(TOG_MAX + 1);
  localparam int unsigned DW_W     = DWELL_BITS + 1;
  localparam int unsigned ST_W     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [4:0]  PAIR_MOD = 5'(MAX_BOUNCES + 1);

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              target_q, target_d;
  logic              noisy_q, noisy_d;
  logic              done_q, done_d;
  logic [TOG_W-1:0]  toggles_q, toggles_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [4:0]        pairs;
  logic [DW_W-1:0]   dwell_reload;

  // Galois right-shift LFSR: every bit takes its upper neighbour, tapped bits also take the output bit.
  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_lfsr
      assign lfsr_d[gi] = lfsr_q[gi+1] ^ (TAPS[gi] & lfsr_q[0]);
    end
  endgenerate
  assign lfsr_d[15] = TAPS[15] & lfsr_q[0];

  assign pairs        = {1'b0, lfsr_q[11:8]} % PAIR_MOD;
  assign dwell_reload = {1'b0, lfsr_q[DWELL_BITS-1:0]} + DW_W'(1);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    noisy_d   = noisy_q;
    toggles_d = toggles_q;
    dwell_d   = dwell_q;
    settle_d  = settle_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clean_in != target_q) begin
          target_d  = clean_in;
          toggles_d = TOG_W'({pairs, 1'b1});
          dwell_d   = DW_W'(1);
          state_d   = BOUNCE;
        end
      end
      BOUNCE: begin
        // The odd toggle count guarantees noisy_q lands on target_q at the last toggle.
        if (dwell_q == DW_W'(1)) begin
          noisy_d   = ~noisy_q;
          toggles_d = toggles_q - TOG_W'(1);
          dwell_d   = dwell_reload;
          if (toggles_q == TOG_W'(1)) begin
            settle_d = ST_W'(SETTLE_CYCLES);
            state_d  = SETTLE;
          end
        end else begin
          dwell_d = dwell_q - DW_W'(1);
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - ST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_EFF;
      target_q  <= INIT_LEVEL;
      noisy_q   <= INIT_LEVEL;
      done_q    <= 1'b0;
      toggles_q <= '0;
      dwell_q   <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      target_q  <= target_d;
      noisy_q   <= noisy_d;
      done_q    <= done_d;
      toggles_q <= toggles_d;
      dwell_q   <= dwell_d;
      settle_q  <= settle_d;
    end
  end

  assign noisy_out = noisy_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

`ifdef BOUNCE_GEN_EDGE_COUNT_EN
  logic [7:0] edge_count_q, edge_count_d;

  always_comb begin
    edge_count_d = edge_count_q + 8'(noisy_d != noisy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count_q <= '0;
    end else begin
      edge_count_q <= edge_count_d;
    end
  end

  assign edge_count = edge_count_q;
`endif

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: four instances with different parameters,
// checked against a timeline model that precomputes each bounce schedule from the LFSR sequence.
module tb_bounce_gen;

  localparam int          D_MB   = 15;
  localparam int          D_DW   = 2;
  localparam int          D_ST   = 2;
  localparam logic [15:0] D_SEED = 16'h1D2B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, clean_a, noisy_a, busy_a, done_a;
  logic rst_bc, clean_bc, noisy_b, busy_b, done_b, noisy_c, busy_c, done_c;
  logic rst_d, clean_d, noisy_d, busy_d, done_d;
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
  logic [7:0] ec_a, ec_b, ec_c, ec_d;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bounce_gen #(.MAX_BOUNCES(0), .SETTLE_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_a), .clean_in(clean_a),
    .noisy_out(noisy_a), .busy(busy_a), .done(done_a)
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
    , .edge_count(ec_a)
`endif
  );

  bounce_gen u_b (
    .clk(clk), .rst_n(rst_bc), .clean_in(clean_bc),
    .noisy_out(noisy_b), .busy(busy_b), .done(done_b)
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
    , .edge_count(ec_b)
`endif
  );

  bounce_gen #(.SEED(16'h0000)) u_c (
    .clk(clk), .rst_n(rst_bc), .clean_in(clean_bc),
    .noisy_out(noisy_c), .busy(busy_c), .done(done_c)
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
    , .edge_count(ec_c)
`endif
  );

  bounce_gen #(.MAX_BOUNCES(D_MB), .DWELL_BITS(D_DW), .SETTLE_CYCLES(D_ST),
               .SEED(D_SEED), .INIT_LEVEL(1'b1)) u_d (
    .clk(clk), .rst_n(rst_d), .clean_in(clean_d),
    .noisy_out(noisy_d), .busy(busy_d), .done(done_d)
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
    , .edge_count(ec_d)
`endif
  );

  // Reference model: id 0 mirrors u_b/u_c (u_c must behave as seed ACE1), id 1 mirrors u_d.
  logic [15:0] m_lfsr [2];
  logic        m_target [2];
  logic        m_noisy [2];
  logic        m_busy [2];
  logic        m_done [2];
  int          m_edge [2];
  int          m_nsched [2];
  int          m_sidx [2];
  int          m_idle_edge [2];
  int          m_sched [2][32];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset(input int id, input logic [15:0] seed, input logic init);
    m_lfsr[id]      = seed;
    m_target[id]    = init;
    m_noisy[id]     = init;
    m_busy[id]      = 1'b0;
    m_done[id]      = 1'b0;
    m_edge[id]      = 0;
    m_nsched[id]    = 0;
    m_sidx[id]      = 0;
    m_idle_edge[id] = 0;
  endtask

  // One clock edge: on a new transition, the full list of toggle edges is derived up front.
  task automatic model_step(input int id, input logic clean, input int mb, input int dw, input int st);
    int e, n, t, d;
    logic [15:0] tmp;
    m_edge[id]++;
    e = m_edge[id];
    m_done[id] = 1'b0;
    if (m_busy[id]) begin
      if (m_sidx[id] < m_nsched[id] && m_sched[id][m_sidx[id]] == e) begin
        m_noisy[id] = ~m_noisy[id];
        m_sidx[id]++;
      end
      if (e == m_idle_edge[id]) begin
        m_busy[id] = 1'b0;
        m_done[id] = 1'b1;
      end
    end else if (clean !== m_target[id]) begin
      m_target[id] = clean;
      m_busy[id]   = 1'b1;
      n   = 2 * (int'(m_lfsr[id][11:8]) % (mb + 1)) + 1;
      tmp = lfsr_next(m_lfsr[id]);
      t   = e + 1;
      for (int k = 0; k < n; k++) begin
        m_sched[id][k] = t;
        d = 1 + int'(tmp & 16'((1 << dw) - 1));
        for (int j = 0; j < d; j++) tmp = lfsr_next(tmp);
        t += d;
      end
      m_nsched[id]    = n;
      m_sidx[id]      = 0;
      m_idle_edge[id] = m_sched[id][n-1] + st + 1;
    end
    m_lfsr[id] = lfsr_next(m_lfsr[id]);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_bc === 1'b1) model_step(0, clean_bc, 7, 4, 64);
    if (rst_d === 1'b1) model_step(1, clean_d, D_MB, D_DW, D_ST);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_bc = 1'b0; rst_d = 1'b0;
    clean_a = 1'b0; clean_bc = 1'b0; clean_d = 1'b1;
    model_reset(0, 16'hACE1, 1'b0);
    model_reset(1, D_SEED, 1'b1);
    cycle();
    cycle();
    n_tests++;
    if ({noisy_a, busy_a, done_a} !== 3'b000) begin
      n_fail++; $display("FAIL reset_a got=%b exp=000", {noisy_a, busy_a, done_a});
    end
    n_tests++;
    if ({noisy_b, busy_b, done_b, noisy_c, busy_c, done_c} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_bc got=%b exp=000000", {noisy_b, busy_b, done_b, noisy_c, busy_c, done_c});
    end
    n_tests++;
    if ({noisy_d, busy_d, done_d} !== 3'b100) begin
      n_fail++; $display("FAIL reset_d got=%b exp=100", {noisy_d, busy_d, done_d});
    end
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
    n_tests++;
    if (ec_d !== 8'd0) begin
      n_fail++; $display("FAIL reset_ec got=%0d exp=0", ec_d);
    end
`endif
    rst_a = 1'b1; rst_bc = 1'b1; rst_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++;
      if ({busy_a, busy_b, busy_c, busy_d, noisy_a, noisy_b, noisy_d} !== 7'b0000001) begin
        n_fail++; $display("FAIL idle_quiet got=%b exp=0000001", {busy_a, busy_b, busy_c, busy_d, noisy_a, noisy_b, noisy_d});
      end
    end
  endtask

  task automatic test_single_edge();
    int first_edge, edges, busy_cnt, busy_first, done_cnt, done_idx;
    logic prev;
    for (int lv = 1; lv >= 0; lv--) begin
      first_edge = -1; edges = 0; busy_cnt = 0; busy_first = -1; done_cnt = 0; done_idx = -1;
      prev = noisy_a;
      clean_a = 1'(lv);
      for (int i = 1; i <= 12; i++) begin
        cycle();
        if (noisy_a !== prev) begin
          if (edges == 0) first_edge = i;
          edges++;
          prev = noisy_a;
        end
        if (busy_a === 1'b1) begin
          if (busy_first < 0) busy_first = i;
          busy_cnt++;
        end
        if (done_a === 1'b1) begin
          done_cnt++;
          done_idx = i;
        end
      end
      n_tests++;
      if (first_edge != 2) begin n_fail++; $display("FAIL single_latency got=%0d exp=2", first_edge); end
      n_tests++;
      if (edges != 1) begin n_fail++; $display("FAIL single_edges got=%0d exp=1", edges); end
      n_tests++;
      if (busy_cnt != 6 || busy_first != 1) begin
        n_fail++; $display("FAIL single_busy got=%0d@%0d exp=6@1", busy_cnt, busy_first);
      end
      n_tests++;
      if (done_cnt != 1 || done_idx != 7) begin
        n_fail++; $display("FAIL single_done got=%0d@%0d exp=1@7", done_cnt, done_idx);
      end
      n_tests++;
      if (noisy_a !== 1'(lv)) begin n_fail++; $display("FAIL single_level got=%b exp=%b", noisy_a, 1'(lv)); end
      $display("[TB] single edge level=%0d latency=%0d busy=%0d", lv, first_edge, busy_cnt);
    end
  endtask

  task automatic test_default_sequence();
    int edges, last_edge, gap, gap_min, gap_max, first_edge;
    bit seen;
    logic prev;
    edges = 0; last_edge = 0; gap_min = 1000; gap_max = 0; first_edge = -1; seen = 0;
    prev = noisy_b;
    clean_bc = 1'b1;
    for (int i = 1; i <= 600 && !seen; i++) begin
      cycle();
      n_tests++;
      if ({noisy_b, busy_b, done_b, noisy_c, busy_c, done_c} !== {m_noisy[0], m_busy[0], m_done[0], m_noisy[0], m_busy[0], m_done[0]}) begin
        n_fail++; $display("FAIL default_model cyc=%0d got=%b exp=%b", i,
          {noisy_b, busy_b, done_b, noisy_c, busy_c, done_c}, {m_noisy[0], m_busy[0], m_done[0]});
      end
      if (noisy_b !== prev) begin
        if (edges == 0) first_edge = i;
        else begin
          gap = i - last_edge;
          if (gap < gap_min) gap_min = gap;
          if (gap > gap_max) gap_max = gap;
        end
        edges++;
        last_edge = i;
        prev = noisy_b;
      end
      if (done_b === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL default_done got=timeout exp=done"); end
    n_tests++;
    if (first_edge != 2) begin n_fail++; $display("FAIL default_latency got=%0d exp=2", first_edge); end
    n_tests++;
    if (edges % 2 != 1 || edges > 15) begin n_fail++; $display("FAIL default_edge_count got=%0d exp=odd<=15", edges); end
    n_tests++;
    if (edges > 1 && (gap_min < 1 || gap_max > 16)) begin
      n_fail++; $display("FAIL default_dwell got=%0d..%0d exp=1..16", gap_min, gap_max);
    end
    n_tests++;
    if (noisy_b !== 1'b1) begin n_fail++; $display("FAIL default_level got=%b exp=1", noisy_b); end
    $display("[TB] default sequence edges=%0d dwell=%0d..%0d", edges, gap_min, gap_max);
  endtask

  task automatic test_ignore();
    bit seen;
    for (int sc = 0; sc < 2; sc++) begin
      // sc 0 ends on the latched level, sc 1 ends on the opposite level
      clean_bc = ~clean_bc;
      for (int i = 0; i < 8 + 600 && !(seen && i > 8); i++) begin
        if (i == 0) seen = 0;
        if (i == 3) clean_bc = ~clean_bc;
        if (i == 4) clean_bc = ~clean_bc;
        if (i == 5 && sc == 1) clean_bc = ~clean_bc;
        cycle();
        n_tests++;
        if ({noisy_b, busy_b, done_b, noisy_c, busy_c, done_c} !== {m_noisy[0], m_busy[0], m_done[0], m_noisy[0], m_busy[0], m_done[0]}) begin
          n_fail++; $display("FAIL ignore_model sc=%0d cyc=%0d got=%b exp=%b", sc, i,
            {noisy_b, busy_b, done_b, noisy_c, busy_c, done_c}, {m_noisy[0], m_busy[0], m_done[0]});
        end
        if (done_b === 1'b1) seen = 1;
      end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL ignore_done sc=%0d got=timeout exp=done", sc); end
      cycle();
      n_tests++;
      if (busy_b !== 1'(sc)) begin n_fail++; $display("FAIL ignore_restart sc=%0d got=%b exp=%b", sc, busy_b, 1'(sc)); end
      $display("[TB] ignore scenario %0d restart=%b", sc, busy_b);
    end
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      cycle();
      n_tests++;
      if ({noisy_b, busy_b, done_b} !== {m_noisy[0], m_busy[0], m_done[0]}) begin
        n_fail++; $display("FAIL ignore_tail cyc=%0d got=%b exp=%b", i, {noisy_b, busy_b, done_b}, {m_noisy[0], m_busy[0], m_done[0]});
      end
      if (done_b === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL ignore_tail_done got=timeout exp=done"); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clean_bc = ~m_target[0];
    for (int i = 0; i < 3; i++) cycle();
    n_tests++;
    if (busy_b !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy got=%b exp=1", busy_b); end
    rst_bc = 1'b0;
    #1;
    n_tests++;
    if ({noisy_b, busy_b, done_b, noisy_c, busy_c, done_c} !== 6'b000000) begin
      n_fail++; $display("FAIL mid_reset_now got=%b exp=000000", {noisy_b, busy_b, done_b, noisy_c, busy_c, done_c});
    end
    model_reset(0, 16'hACE1, 1'b0);
    clean_bc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if ({done_b, busy_b, done_c, busy_c} !== 4'b0000) begin
        n_fail++; $display("FAIL mid_no_done got=%b exp=0000", {done_b, busy_b, done_c, busy_c});
      end
    end
    rst_bc = 1'b1;
    cycle();
    cycle();
    clean_bc = 1'b1;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      cycle();
      n_tests++;
      if ({noisy_b, busy_b, done_b, noisy_c, busy_c, done_c} !== {m_noisy[0], m_busy[0], m_done[0], m_noisy[0], m_busy[0], m_done[0]}) begin
        n_fail++; $display("FAIL mid_restart cyc=%0d got=%b exp=%b", i,
          {noisy_b, busy_b, done_b, noisy_c, busy_c, done_c}, {m_noisy[0], m_busy[0], m_done[0]});
      end
      if (done_b === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL mid_restart_done got=timeout exp=done"); end
    $display("[TB] reset mid-bounce recovered level=%b", noisy_b);
  endtask

  task automatic test_init_mismatch();
    bit seen;
    rst_d = 1'b0;
    clean_d = 1'b0;
    model_reset(1, D_SEED, 1'b1);
    cycle();
    n_tests++;
    if ({noisy_d, busy_d, done_d} !== 3'b100) begin
      n_fail++; $display("FAIL init_reset got=%b exp=100", {noisy_d, busy_d, done_d});
    end
    rst_d = 1'b1;
    cycle();
    n_tests++;
    if (busy_d !== 1'b1) begin n_fail++; $display("FAIL init_start got=%b exp=1", busy_d); end
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle();
      n_tests++;
      if ({noisy_d, busy_d, done_d} !== {m_noisy[1], m_busy[1], m_done[1]}) begin
        n_fail++; $display("FAIL init_model cyc=%0d got=%b exp=%b", i, {noisy_d, busy_d, done_d}, {m_noisy[1], m_busy[1], m_done[1]});
      end
      if (done_d === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen || noisy_d !== 1'b0) begin
      n_fail++; $display("FAIL init_final got=%b/%0d exp=0/done", noisy_d, seen);
    end
  endtask

  task automatic test_edge_count();
    int tog, total;
    bit seen;
    logic prev;
    rst_d = 1'b0;
    clean_d = 1'b1;
    model_reset(1, D_SEED, 1'b1);
    cycle();
    rst_d = 1'b1;
    total = 0;
    for (int t = 0; t < 20; t++) begin
      clean_d = ~clean_d;
      tog = 0;
      prev = noisy_d;
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
        cycle();
        n_tests++;
        if ({noisy_d, busy_d, done_d} !== {m_noisy[1], m_busy[1], m_done[1]}) begin
          n_fail++; $display("FAIL edge_model tr=%0d cyc=%0d got=%b exp=%b", t, i, {noisy_d, busy_d, done_d}, {m_noisy[1], m_busy[1], m_done[1]});
        end
        if (noisy_d !== prev) begin
          tog++;
          prev = noisy_d;
        end
        if (done_d === 1'b1) seen = 1;
      end
      n_tests++;
      if (!seen || tog % 2 != 1 || tog > 31) begin
        n_fail++; $display("FAIL edge_toggles tr=%0d got=%0d/%0d exp=odd<=31/done", t, tog, seen);
      end
      total += tog;
`ifdef BOUNCE_GEN_EDGE_COUNT_EN
      n_tests++;
      if (ec_d !== 8'(total)) begin
        n_fail++; $display("FAIL edge_count tr=%0d got=%0d exp=%0d", t, ec_d, 8'(total));
      end
`endif
      $display("[TB] transition %0d level=%b toggles=%0d total=%0d", t, clean_d, tog, total);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(49) == 0) clean_bc = ~clean_bc;
      if ($urandom_range(7) == 0) clean_d = ~clean_d;
      cycle();
      n_tests++;
      if ({noisy_b, busy_b, done_b, noisy_c, busy_c, done_c} !== {m_noisy[0], m_busy[0], m_done[0], m_noisy[0], m_busy[0], m_done[0]}) begin
        n_fail++; $display("FAIL random_bc cyc=%0d got=%b exp=%b", i,
          {noisy_b, busy_b, done_b, noisy_c, busy_c, done_c}, {m_noisy[0], m_busy[0], m_done[0]});
      end
      n_tests++;
      if ({noisy_d, busy_d, done_d} !== {m_noisy[1], m_busy[1], m_done[1]}) begin
        n_fail++; $display("FAIL random_d cyc=%0d got=%b exp=%b", i, {noisy_d, busy_d, done_d}, {m_noisy[1], m_busy[1], m_done[1]});
      end
    end
    $display("[TB] random run complete");
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_default_sequence();
    test_ignore();
    test_reset_mid();
    test_init_mismatch();
    test_edge_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
